// File: rtl/imem_fetch_arbiter.sv
// Shares the instruction memory between CPU fetch and a debug read port.
// Each grant holds ImemAddr for WAIT_CYCLES edges, then captures ImemData for the winner.
module imem_fetch_arbiter #(
  parameter int WAIT_CYCLES      = 2,
  parameter int MAX_FETCH_STREAK = 4
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        FetchReq,
  input  logic [63:0] FetchAddr,
  output logic        FetchAck,
  output logic        FetchValid,
  output logic [31:0] FetchInstr,
  input  logic        Flush,
  input  logic        DbgReq,
  input  logic [63:0] DbgAddr,
  output logic        DbgAck,
  output logic        DbgValid,
  output logic [31:0] DbgData,
  output logic [63:0] ImemAddr,
  input  logic [31:0] ImemData,
  output logic        Busy
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam int SW = $clog2(MAX_FETCH_STREAK + 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic {OWN_FETCH, OWN_DBG} owner_t;

  state_t        state;
  owner_t        owner;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;

  logic fetch_elig;
  logic dbg_elig;
  logic streak_full;
  logic dbg_wins;
  logic can_grant;

  assign fetch_elig  = FetchReq && !Flush;
  assign dbg_elig    = DbgReq;
  assign streak_full = (streak == SW'(MAX_FETCH_STREAK));
  // Debug only beats an eligible fetch once fetch has used up its streak.
  assign dbg_wins    = dbg_elig && (!fetch_elig || streak_full);
  assign can_grant   = resetl && (state == ST_IDLE);

  assign FetchAck = can_grant && fetch_elig && !dbg_wins;
  assign DbgAck   = can_grant && dbg_wins;
  assign Busy     = (state == ST_WAIT);

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state      <= ST_IDLE;
      owner      <= OWN_FETCH;
      cnt        <= '0;
      streak     <= '0;
      ImemAddr   <= '0;
      FetchInstr <= '0;
      DbgData    <= '0;
      FetchValid <= 1'b0;
      DbgValid   <= 1'b0;
    end else begin
      FetchValid <= 1'b0;
      DbgValid   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (FetchAck) begin
            ImemAddr <= FetchAddr;
            owner    <= OWN_FETCH;
            cnt      <= CW'(WAIT_CYCLES);
            state    <= ST_WAIT;
            if (!DbgReq)
              streak <= '0;
            else if (!streak_full)
              streak <= streak + SW'(1);
          end else if (DbgAck) begin
            ImemAddr <= DbgAddr;
            owner    <= OWN_DBG;
            cnt      <= CW'(WAIT_CYCLES);
            state    <= ST_WAIT;
            streak   <= '0;
          end
        end
        ST_WAIT: begin
          // A redirect kills an in-flight fetch even on its capture edge.
          if (owner == OWN_FETCH && Flush) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= ST_IDLE;
            if (owner == OWN_FETCH) begin
              FetchInstr <= ImemData;
              FetchValid <= 1'b1;
            end else begin
              DbgData  <= ImemData;
              DbgValid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: ack priority table, scoreboarded reads, streak, flush and reset sequences.
module tb_imem_fetch_arbiter;

  localparam int WAIT_CYCLES      = 2;
  localparam int MAX_FETCH_STREAK = 4;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic        FetchReq = 1'b0;
  logic [63:0] FetchAddr = '0;
  logic        FetchAck;
  logic        FetchValid;
  logic [31:0] FetchInstr;
  logic        Flush = 1'b0;
  logic        DbgReq = 1'b0;
  logic [63:0] DbgAddr = '0;
  logic        DbgAck;
  logic        DbgValid;
  logic [31:0] DbgData;
  logic [63:0] ImemAddr;
  logic [31:0] ImemData;
  logic        Busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_cyc = 0;
  int fv_cyc = 0;
  logic [31:0] exp_f[$];
  logic [31:0] exp_d[$];

  imem_fetch_arbiter #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .MAX_FETCH_STREAK(MAX_FETCH_STREAK)
  ) dut (
    .CLK(CLK), .resetl(resetl),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchAck(FetchAck),
    .FetchValid(FetchValid), .FetchInstr(FetchInstr), .Flush(Flush),
    .DbgReq(DbgReq), .DbgAddr(DbgAddr), .DbgAck(DbgAck),
    .DbgValid(DbgValid), .DbgData(DbgData),
    .ImemAddr(ImemAddr), .ImemData(ImemData), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Instruction memory contents seen by the block.
  function automatic logic [31:0] mem(input logic [63:0] a);
    case (a)
      64'h0:   return 32'hF84003E9;
      64'h14:  return 32'hAA0B014A;
      64'h28:  return 32'h17FFFFFD;
      64'h50:  return 32'h91000421;
      64'h54:  return 32'hF841C3EA;
      default: return a[31:0] ^ a[63:32] ^ 32'h5A5AC3C3;
    endcase
  endfunction

  assign ImemData = mem(ImemAddr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every valid pulse must match the oldest expected word for its port.
  always @(negedge CLK) begin
    if (resetl) begin
      if (Busy) busy_cyc++;
      if (FetchValid || DbgValid) chk("valid_exclusive", {62'd0, FetchValid, DbgValid} == 64'd3, 64'd0);
      if (FetchValid) begin
        fv_cyc = cyc;
        if (exp_f.size() == 0) chk("unexpected_fetchvalid", {32'd0, FetchInstr}, 64'hDEAD);
        else chk("fetch_instr", {32'd0, FetchInstr}, {32'd0, exp_f.pop_front()});
      end
      if (DbgValid) begin
        if (exp_d.size() == 0) chk("unexpected_dbgvalid", {32'd0, DbgData}, 64'hDEAD);
        else chk("dbg_data", {32'd0, DbgData}, {32'd0, exp_d.pop_front()});
      end
    end
  end

  // Raises one request, waits for its ack, and returns at the negedge after the grant edge.
  task automatic issue(input bit dbg, input logic [63:0] addr, input bit want, output int gcyc);
    bit got;
    got = 1'b0;
    gcyc = -1;
    @(negedge CLK);
    if (dbg) begin DbgReq = 1'b1; DbgAddr = addr; end
    else begin FetchReq = 1'b1; FetchAddr = addr; end
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (dbg ? DbgAck : FetchAck) begin
        got = 1'b1;
        gcyc = cyc + 1;
        if (want) begin
          if (dbg) exp_d.push_back(mem(addr));
          else exp_f.push_back(mem(addr));
        end
      end
      @(negedge CLK);
    end
    FetchReq = 1'b0;
    DbgReq = 1'b0;
    if (!got) chk("grant_timeout", 64'd0, 64'd1);
    else chk("imem_addr", ImemAddr, addr);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_f.size() != 0 || exp_d.size() != 0) && n < 50) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    chk(name, 64'(exp_f.size() + exp_d.size()), 64'd0);
  endtask

  typedef struct {
    logic freq;
    logic flush;
    logic dreq;
    logic exp_fack;
    logic exp_dack;
  } ack_vec_t;

  ack_vec_t vecs[8];

  typedef struct {
    bit          dbg;
    logic [63:0] addr;
  } rd_vec_t;

  rd_vec_t rds[4];

  initial begin
    int g0, g1, b0, f0, gtmp, dgrants, fcnt;
    int runs[2];
    logic [31:0] saved;

    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rds[0] = '{1'b1, 64'hFFFF_0000_1234_5678};
    rds[1] = '{1'b0, 64'h8000_0000_0000_0104};
    rds[2] = '{1'b1, 64'h14};
    rds[3] = '{1'b0, 64'h0000_0001_0000_0020};

    // Reset: requests pending but acks must stay low.
    FetchReq = 1'b1;
    DbgReq = 1'b1;
    #1;
    chk("reset_fetchack", {63'd0, FetchAck}, 64'd0);
    chk("reset_dbgack", {63'd0, DbgAck}, 64'd0);
    chk("reset_imemaddr", ImemAddr, 64'd0);
    chk("reset_busy", {63'd0, Busy}, 64'd0);
    chk("reset_valids", {62'd0, FetchValid, DbgValid}, 64'd0);
    FetchReq = 1'b0;
    DbgReq = 1'b0;
    repeat (2) @(negedge CLK);
    resetl = 1'b1;

    // Combinational ack priority in IDLE with streak 0; inputs dropped before the edge.
    foreach (vecs[i]) begin
      @(negedge CLK);
      FetchReq = vecs[i].freq;
      Flush = vecs[i].flush;
      DbgReq = vecs[i].dreq;
      FetchAddr = 64'h40;
      DbgAddr = 64'h44;
      #1;
      chk($sformatf("ack_tbl%0d_fetch", i), {63'd0, FetchAck}, {63'd0, vecs[i].exp_fack});
      chk($sformatf("ack_tbl%0d_dbg", i), {63'd0, DbgAck}, {63'd0, vecs[i].exp_dack});
      FetchReq = 1'b0;
      Flush = 1'b0;
      DbgReq = 1'b0;
    end

    // Single fetch: capture WAIT_CYCLES edges after grant, Busy for WAIT_CYCLES cycles.
    b0 = busy_cyc;
    issue(1'b0, 64'h0, 1'b1, g0);
    drain("single_drain");
    chk("single_latency", 64'(fv_cyc - g0), 64'(WAIT_CYCLES));
    chk("single_busy", 64'(busy_cyc - b0), 64'(WAIT_CYCLES));

    // Back-to-back fetches: second grant lands in the first Valid cycle.
    issue(1'b0, 64'h14, 1'b1, g0);
    issue(1'b0, 64'h28, 1'b1, g1);
    chk("b2b_grant_gap", 64'(g1 - g0), 64'(WAIT_CYCLES + 1));
    @(negedge CLK);
    f0 = fv_cyc;
    drain("b2b_drain");
    chk("b2b_valid_gap", 64'(fv_cyc - f0), 64'(WAIT_CYCLES + 1));

    // Full-width addresses through both ports.
    foreach (rds[i]) issue(rds[i].dbg, rds[i].addr, 1'b1, gtmp);
    drain("rd_table_drain");

    // Starvation guard: two rounds of MAX_FETCH_STREAK fetches then a debug grant.
    @(negedge CLK);
    FetchReq = 1'b1; FetchAddr = 64'h0;
    DbgReq = 1'b1; DbgAddr = 64'h54;
    fcnt = 0; dgrants = 0; runs[0] = -1; runs[1] = -1;
    for (int i = 0; i < 80 && dgrants < 2; i++) begin
      #1;
      if (FetchAck) begin exp_f.push_back(mem(FetchAddr)); fcnt++; end
      if (DbgAck) begin
        exp_d.push_back(mem(DbgAddr));
        runs[dgrants] = fcnt;
        fcnt = 0;
        dgrants++;
      end
      @(negedge CLK);
    end
    FetchReq = 1'b0;
    DbgReq = 1'b0;
    chk("streak_dbg_grants", 64'(dgrants), 64'd2);
    chk("streak_run0", 64'(runs[0]), 64'(MAX_FETCH_STREAK));
    chk("streak_run1", 64'(runs[1]), 64'(MAX_FETCH_STREAK));
    drain("streak_drain");

    // Flush on the edge after a fetch grant; pending debug takes the next IDLE cycle.
    saved = FetchInstr;
    @(negedge CLK);
    FetchReq = 1'b1; FetchAddr = 64'h50;
    DbgReq = 1'b1; DbgAddr = 64'h54;
    #1;
    chk("flush_fetch_wins", {63'd0, FetchAck}, 64'd1);
    @(negedge CLK);
    chk("flush_busy_before", {63'd0, Busy}, 64'd1);
    FetchReq = 1'b0;
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    #1;
    chk("flush_busy_drop", {63'd0, Busy}, 64'd0);
    chk("flush_dbgack", {63'd0, DbgAck}, 64'd1);
    exp_d.push_back(mem(64'h54));
    @(negedge CLK);
    DbgReq = 1'b0;
    drain("flush_drain");
    chk("flush_instr_hold", {32'd0, FetchInstr}, {32'd0, saved});

    // Flush on the capture edge itself also suppresses the fetch.
    issue(1'b0, 64'h14, 1'b0, gtmp);
    repeat (WAIT_CYCLES - 1) @(negedge CLK);
    Flush = 1'b1;
    @(negedge CLK);
    Flush = 1'b0;
    chk("flush_capture_instr", {32'd0, FetchInstr}, {32'd0, saved});
    chk("flush_capture_valid", {63'd0, FetchValid}, 64'd0);

    // Reset during an in-flight debug read.
    issue(1'b1, 64'h0, 1'b0, gtmp);
    resetl = 1'b0;
    #1;
    chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
    chk("rst_mid_dbgdata", {32'd0, DbgData}, 64'd0);
    chk("rst_mid_instr", {32'd0, FetchInstr}, 64'd0);
    chk("rst_mid_imemaddr", ImemAddr, 64'd0);
    chk("rst_mid_valids", {62'd0, FetchValid, DbgValid}, 64'd0);
    repeat (2) @(negedge CLK);
    resetl = 1'b1;
    repeat (6) @(negedge CLK);
    issue(1'b0, 64'h28, 1'b1, gtmp);
    drain("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=%0d", cyc, 0);
    $fatal(1);
  end

endmodule
